hex_disp_ctrl: RTL
==================

HEX_DISP_CTRL -- requirements
Module: hex_disp_ctrl

Interface
REQ-001 SHALL have parameter BLINK_DIV, default 25_000_000: clk cycles per blink half-period (legal range 2..2^26).
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1: requester offers a display word.
REQ-005 SHALL have port in_ready, output, 1: controller can accept a word.
REQ-006 SHALL have port in_data, input, 24: six hex nibbles; nibble i maps to HEXi.
REQ-007 SHALL have port in_lzs, input, 1: leading-zero suppression for this word.
REQ-008 SHALL have port in_blink, input, 1: blink enable for this word.
REQ-009 SHALL have port busy, output, 1: a scan is in progress.
REQ-010 SHALL have ports HEX0..HEX5, output, 7 each: active-low segment drives.

Function
REQ-011 SHALL implement states IDLE and SCAN; in_ready = 1 in IDLE only; busy = 1 in SCAN only.
REQ-012 SHALL accept a word on a rising edge where in_valid & in_ready, latching in_data, in_lzs and in_blink and entering SCAN with digit index 0.
REQ-013 SHALL ignore in_valid while in SCAN; the requester holds the word until accepted.
REQ-014 SHALL, in SCAN, drive the latched nibble at the current index into one shared seg7 decoder and register its output into segment store slot idx on each edge, idx 0..5.
REQ-015 SHALL return to IDLE on the edge that writes slot 5; accepted at edge k -> slot i updated at edge k+1+i, in_ready high after edge k+6.
REQ-016 SHALL, with in_lzs latched, write 7'h7F into slot i (i >= 1) when latched nibbles i..5 are all zero; slot 0 is never suppressed.
REQ-017 SHALL display nibble 4'hF as blank, as the shared decoder defines it; no alternate F glyph is provided.
REQ-018 SHALL leave slots not yet rewritten holding the previous word during SCAN (per-digit update, no global blank).
REQ-019 SHALL run a free-running blink counter 0..BLINK_DIV-1 that toggles a phase bit on wrap; phase starts at ON.
REQ-020 SHALL drive HEXi = 7'h7F when latched blink is 1 and phase is OFF, else HEXi = slot i.
REQ-021 SHALL apply a newly latched blink value from the acceptance edge; the counter is not restarted by acceptance.

Reset
REQ-022 SHALL, on reset assertion, immediately force state IDLE, idx 0, all slots 7'h7F, latched blink 0, latched lzs 0, counter 0, phase ON.
REQ-023 SHALL, while reset is asserted, hold HEX0..HEX5 = 7'h7F, busy = 0, in_ready = 1; a scan interrupted by reset is discarded.
REQ-024 SHALL not accept a word on any edge where reset is asserted.

Structure
REQ-025 SHALL place the state enum, NUM_DIGITS = 6 and SEG_BLANK = 7'h7F in package hex_disp_pkg.
REQ-026 SHALL instantiate exactly one seg7 sub-module, time-shared across digits.

Verification
REQ-027 SHALL test: after reset, send 24'h12_34AB (lzs 0, blink 0) -> HEX5..HEX0 = 1,2,3,4,A,b; in_ready low 6 cycles; busy high 6 cycles.
REQ-028 SHALL test: 24'h00_0050, lzs 1 -> HEX5..HEX2 = 7'h7F, HEX1 = 5, HEX0 = 0; 24'h000000, lzs 1 -> only HEX0 = 0.
REQ-029 SHALL test: in_valid held during SCAN with a different word -> second word accepted only after edge k+6, first word fully displayed first.
REQ-030 SHALL test: BLINK_DIV = 4, blink 1 -> all HEX toggle between the pattern and 7'h7F every 4 cycles; blink 0 word -> steady.
REQ-031 SHALL test: reset asserted at slot 3 of a scan -> all HEX = 7'h7F asynchronously, busy = 0, next word displays correctly.
REQ-032 SHALL test: 24'hFFFFFF -> all digits blank; 24'h0F0000, lzs 1 -> HEX5 blank, HEX4 blank (F), HEX3..HEX1 = 0, HEX0 = 0.

Source files
------------

// File: rtl/hex_disp_pkg.sv
// Shared definitions for the six-digit hex display controller: controller
// states, digit count, index width and the all-segments-off pattern.
package hex_disp_pkg;

    // Controller is either waiting for a word or walking the six digits.
    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam int NUM_DIGITS = 6;
    localparam int IDX_W      = 3;
    localparam int NIB_W      = 4;
    localparam int SEG_W      = 7;
    localparam int DATA_W     = NUM_DIGITS * NIB_W;

    // Segments are active-low, so all ones turns every segment off.
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // Index of the final digit; writing this slot ends a scan.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

endpackage

// File: rtl/hex_disp_seg7.sv
// Hex nibble to active-low seven-segment decoder (bit order gfedcba).
// Nibble F decodes to blank; there is no separate F glyph.
module hex_disp_seg7
    import hex_disp_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [SEG_W-1:0] seg
);

    // Purely combinational glyph lookup.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any branch, so no path leaves it unassigned and no latch is inferred.
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_disp_ctrl.sv
// Six-digit hex display controller. A word is accepted over a valid/ready
// handshake, then one shared decoder fills the segment store one digit per
// clock. Optional leading-zero suppression and a free-running blink apply.
module hex_disp_ctrl
    import hex_disp_pkg::*;
#(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_lzs,
    input  logic              in_blink,
    output logic              busy,
    output logic [SEG_W-1:0]  HEX0,
    output logic [SEG_W-1:0]  HEX1,
    output logic [SEG_W-1:0]  HEX2,
    output logic [SEG_W-1:0]  HEX3,
    output logic [SEG_W-1:0]  HEX4,
    output logic [SEG_W-1:0]  HEX5
);

    localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data_q;
    logic              lzs_q;
    logic              blink_q;
    logic [NIB_W-1:0]  cur_nib;
    logic [SEG_W-1:0]  dec_seg;
    logic [NUM_DIGITS-1:0] upper_zero;
    logic              suppress;
    logic [SEG_W-1:0]  slot [NUM_DIGITS];
    logic [SEG_W-1:0]  disp [NUM_DIGITS];
    logic [CNT_W-1:0]  blink_cnt;
    logic              phase_on;
    logic              blank_now;

    // State register; reset abandons any scan in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake decode: ready only in IDLE, busy only in SCAN.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Digit index: restarts at 0 on acceptance, advances once per scan cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx <= '0;
        end else if (accept) begin
            idx <= '0;
        end else if (state == SCAN) begin
            // NOTE: sequential state always uses non-blocking assignment so
            // every register samples its inputs from before the edge.
            idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end
    end

    // Word latch: data and per-word options captured on the acceptance edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q  <= '0;
            lzs_q   <= 1'b0;
            blink_q <= 1'b0;
        end else if (accept) begin
            data_q  <= in_data;
            lzs_q   <= in_lzs;
            blink_q <= in_blink;
        end
    end

    // Select the nibble for the digit currently being written.
    assign cur_nib = data_q[{idx, 2'b00} +: NIB_W];

    // Single decoder shared by all six digits.
    hex_disp_seg7 u_seg7 (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    // upper_zero[i] is set when nibble i and every nibble above it are zero.
    always_comb begin
        logic run_zero;
        run_zero   = 1'b1;
        upper_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            run_zero      = run_zero & (data_q[i*NIB_W +: NIB_W] == '0);
            upper_zero[i] = run_zero;
        end
    end

    // Digit 0 always shows, so a zero word still reads as "0".
    assign suppress = lzs_q && (idx != '0) && upper_zero[idx];

    // Segment store: one slot rewritten per scan cycle, others keep old word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: this small store is reset because its contents drive the
            // display directly; a large RAM would normally be left unreset.
            for (int i = 0; i < NUM_DIGITS; i++) begin
                slot[i] <= SEG_BLANK;
            end
        end else if (state == SCAN) begin
            slot[idx] <= suppress ? SEG_BLANK : dec_seg;
        end
    end

    // Free-running blink timer; acceptance never restarts it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            phase_on  <= 1'b1;
        end else if (blink_cnt == CNT_MAX) begin
            blink_cnt <= '0;
            phase_on  <= ~phase_on;
        end else begin
            blink_cnt <= blink_cnt + CNT_W'(1);
        end
    end

    assign blank_now = blink_q && !phase_on;

    // Output stage: blank everything during the blink OFF phase.
    always_comb begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
            disp[i] = blank_now ? SEG_BLANK : slot[i];
        end
    end

    assign HEX0 = disp[0];
    assign HEX1 = disp[1];
    assign HEX2 = disp[2];
    assign HEX3 = disp[3];
    assign HEX4 = disp[4];
    assign HEX5 = disp[5];

endmodule
